burst_fifo: RTL and testbench

//  Parametrised single-clock FIFO for the pixel/DDR path; next generation of the burst FIFOs.

---
 rtl/burst_fifo.sv | 110 +++++++++++
 tb/tb_burst_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : burst_fifo
// Brief    : Single-clock FWFT FIFO with exact occupancy, sticky over/underflow
//            flags, flush, and a burst-credit handshake for DDR bursts.
// Revision : 1.0 - initial release
// ============================================================================
module burst_fifo #(
    parameter int DW        = 24,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int MODE      = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_incr_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          out_incr_i,
    output logic [DW-1:0] out_data_o,
    output logic          burst_o,
    input  logic          burst_ack_i,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int            LEN     = 2**AW;
    localparam logic [AW+1:0] c_len   = (AW+2)'(LEN);
    localparam logic [AW+1:0] c_burst = (AW+2)'(BURST_LEN);

    logic [DW-1:0] r_mem [LEN];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [AW:0]   r_pend;
    logic          r_ovf;
    logic          r_udf;

    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_ack_acc;
    logic          w_dec;
    logic          w_burst;
    logic          w_clear;
    logic [AW+1:0] w_level_ext;
    logic [AW+1:0] w_pend_ext;
    logic [AW+1:0] w_pend_sum;
    logic [AW:0]   w_pend_nxt;
    logic [AW:0]   w_level_nxt;

    assign w_clear     = !rst_ni || flush_i;
    assign w_level_ext = {1'b0, r_level};
    assign w_pend_ext  = {1'b0, r_pend};

    assign empty_o = (r_level == '0);
    assign full_o  = (w_level_ext == c_len);

    // A read from empty is never rescued by a same-cycle write.
    assign w_rd_acc  = out_incr_i && !empty_o;
    assign w_wr_acc  = in_incr_i && (!full_o || w_rd_acc);
    assign w_ack_acc = burst_ack_i && w_burst;

    // Sums stay below 3*LEN, so AW+2 bits never wrap.
    if (MODE == 0) begin : g_prefetch
        assign w_burst = (w_level_ext + w_pend_ext + c_burst) <= c_len;
        assign w_dec   = (r_pend != '0) && w_wr_acc;
    end else begin : g_drain
        assign w_burst = w_level_ext >= (w_pend_ext + c_burst);
        assign w_dec   = (r_pend != '0) && w_rd_acc;
    end

    assign w_pend_sum = w_pend_ext + (w_ack_acc ? c_burst : '0)
                        - {{(AW+1){1'b0}}, w_dec};
    assign w_pend_nxt = (w_pend_sum > c_len) ? c_len[AW:0] : w_pend_sum[AW:0];

    assign w_level_nxt = r_level + {{AW{1'b0}}, w_wr_acc} - {{AW{1'b0}}, w_rd_acc};

    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
            if (in_incr_i && !w_wr_acc)  r_ovf <= 1'b1;
            if (out_incr_i && !w_rd_acc) r_udf <= 1'b1;
            r_level <= w_level_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!w_clear && w_wr_acc) r_mem[r_wptr] <= in_data_i;
    end

    assign out_data_o = r_mem[r_rptr];
    assign burst_o    = w_burst;
    assign level_o    = r_level;
    assign ovf_o      = r_ovf;
    assign udf_o      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_burst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_fifo
// Brief    : Scoreboard bench driving a prefetch and a drain burst_fifo in step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_fifo;

    localparam int DW  = 24;
    localparam int AW  = 4;
    localparam int BL  = 4;
    localparam int LEN = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_incr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_incr = 1'b0;
    logic          ack = 1'b0;

    logic [DW-1:0] out0, out1;
    logic          burst0, burst1, full0, full1, empty0, empty1;
    logic          ovf0, ovf1, udf0, udf1;
    logic [AW:0]   level0, level1;

    int total = 0;
    int bad   = 0;

    int            m_level;
    int            m_pend [2];
    bit            m_ovf, m_udf;
    logic [DW-1:0] q [$];

    always #5 clk = ~clk;

    burst_fifo #(.DW(DW), .AW(AW), .BURST_LEN(BL), .MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_incr_i(in_incr), .in_data_i(in_data), .out_incr_i(out_incr),
        .out_data_o(out0), .burst_o(burst0), .burst_ack_i(ack),
        .level_o(level0), .full_o(full0), .empty_o(empty0),
        .ovf_o(ovf0), .udf_o(udf0)
    );

    burst_fifo #(.DW(DW), .AW(AW), .BURST_LEN(BL), .MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_incr_i(in_incr), .in_data_i(in_data), .out_incr_i(out_incr),
        .out_data_o(out1), .burst_o(burst1), .burst_ack_i(ack),
        .level_o(level1), .full_o(full1), .empty_o(empty1),
        .ovf_o(ovf1), .udf_o(udf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_burst(input int m);
        if (m == 0) return (LEN - m_level - m_pend[0]) >= BL;
        else        return (m_level - m_pend[1]) >= BL;
    endfunction

    task automatic check_all();
        check("level0", 32'(level0), 32'(m_level));
        check("level1", 32'(level1), 32'(m_level));
        check("full0",  32'(full0),  32'(m_level == LEN));
        check("full1",  32'(full1),  32'(m_level == LEN));
        check("empty0", 32'(empty0), 32'(m_level == 0));
        check("empty1", 32'(empty1), 32'(m_level == 0));
        check("ovf0",   32'(ovf0),   32'(m_ovf));
        check("ovf1",   32'(ovf1),   32'(m_ovf));
        check("udf0",   32'(udf0),   32'(m_udf));
        check("udf1",   32'(udf1),   32'(m_udf));
        check("burst0", 32'(burst0), 32'(m_burst(0)));
        check("burst1", 32'(burst1), 32'(m_burst(1)));
        check("pend0",  32'(dut0.r_pend), 32'(m_pend[0]));
        check("pend1",  32'(dut1.r_pend), 32'(m_pend[1]));
        if (q.size() > 0) begin
            check("head0", 32'(out0), 32'(q[0]));
            check("head1", 32'(out1), 32'(q[0]));
        end
    endtask

    // One clock: drive at the falling edge, update the model, check after the next falling edge.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                        input bit ak, input bit fl, input bit rs);
        bit            rd_acc, wr_acc;
        int            np [2];
        logic [DW-1:0] exp;
        in_incr  = wr;
        in_data  = d;
        out_incr = rd;
        ack      = ak;
        flush    = fl;
        rst_n    = rs;
        if (!rs || fl) begin
            m_level = 0; m_pend[0] = 0; m_pend[1] = 0;
            m_ovf = 1'b0; m_udf = 1'b0;
            q.delete();
        end else begin
            rd_acc = rd && (m_level != 0);
            wr_acc = wr && ((m_level != LEN) || rd_acc);
            for (int m = 0; m < 2; m++) begin
                np[m] = m_pend[m];
                if (ak && m_burst(m)) np[m] += BL;
                if (m_pend[m] > 0 && ((m == 0) ? wr_acc : rd_acc)) np[m] -= 1;
            end
            m_pend[0] = np[0];
            m_pend[1] = np[1];
            if (rd_acc) begin
                exp = q.pop_front();
                check("rd0", 32'(out0), 32'(exp));
                check("rd1", 32'(out1), 32'(exp));
            end
            if (wr_acc) q.push_back(d);
            m_level += int'(wr_acc) - int'(rd_acc);
            if (wr && !wr_acc) m_ovf = 1'b1;
            if (rd && !rd_acc) m_udf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        // 1: reset and idle
        step(0, '0, 0, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1);
        // 2: one prefetch credit consumed by four writes, then drain
        step(0, '0, 0, 1, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)  step(0, '0, 1, 0, 0, 1);
        // 3: fill, overflow, simultaneous read+write when full, then empty out
        for (int i = 0; i < LEN; i++) step(1, DW'(i + 16), 0, 0, 0, 1);
        step(1, 24'h00DEAD, 0, 0, 0, 1);
        step(1, 24'h000777, 1, 0, 0, 1);
        for (int i = 0; i < LEN; i++) step(0, '0, 1, 0, 0, 1);
        // 4: read from empty with a same-cycle write
        step(1, 24'hABCDEF, 1, 0, 0, 1);
        step(0, '0, 0, 0, 0, 1);
        step(0, '0, 1, 0, 0, 1);
        // 5: drain-side burst availability, then pointer wrap
        step(0, '0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, DW'(i + 32'h100), 0, 0, 0, 1);
        step(1, 24'h000103, 0, 0, 0, 1);
        step(0, '0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0, 1);
        for (int i = 0; i < 43; i++) step(i < 40, DW'($urandom), i >= 3, 0, 0, 1);
        // 6: mid-burst flush, then mid-burst reset with flush also asserted
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step(1, DW'(i + 32'h200), 0, 0, 0, 1);
            step(0, '0, 0, 1, 0, 1);
            step(1, 24'h000204, 0, 0, 0, 1);
            check("mid_pend", 32'(dut0.r_pend), 32'd3);
            step(1, 24'h0000FF, 1, 1, 1, (r == 0));
            step(0, '0, 0, 0, 0, 1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
